keystream_serialiser: RTL and testbench
=======================================

# keystream_serialiser

Byte-serial transmitter for ChaCha20 state matrices, the producer side of the byte stream the matrix buffer collects. It accepts one 16-word (512-bit) state matrix per handshake from the block core and emits it as 64 bytes, one per cycle under valid/ready flow control, in RFC 8439 serialisation order. It counts matrices and signals completion after a burst of NUM_MATRICES blocks, which is exactly one full buffer load downstream.

## Interface
- DATA_SIZE, 8, output byte width
- WORD_SIZE, 32, state word width
- NUM_WORDS, 16, words per state matrix; bytes per block = NUM_WORDS*WORD_SIZE/DATA_SIZE = 64
- NUM_MATRICES, 20, matrices per burst
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE
- block_valid  in  1  block_in holds a valid matrix
- block_in  in  NUM_WORDS x WORD_SIZE (unpacked [0:NUM_WORDS-1])  state matrix, word 0 first
- block_ready  out  1  serialiser can capture a matrix
- byte_out  out  DATA_SIZE  current output byte
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  downstream accepts byte this cycle
- byte_last  out  1  byte_out is byte 63 of its block (qualified by byte_valid)
- busy  out  1  high in any state other than IDLE
- block_count  out  $clog2(NUM_MATRICES+1)  blocks fully transmitted in current burst
- burst_done  out  1  one-cycle pulse after final byte of final block is accepted

## Operation
- States: IDLE, WAIT_BLK, SEND, DONE.
- IDLE: block_ready=0, byte_valid=0. start=1 -> WAIT_BLK, block_count cleared to 0.
- WAIT_BLK: block_ready=1. block_valid&&block_ready -> capture block_in into internal 512-bit holding register, byte index := 0, -> SEND.
- SEND: byte_valid=1; byte_out = byte (idx%4) of word (idx/4), little-endian within word (byte 0 = bits 7:0). Transfer when byte_valid&&byte_ready: idx increments.
  - Transfer at idx=63: block_count increments; if new count == NUM_MATRICES -> DONE, else -> WAIT_BLK.
  - byte_ready=0: byte_out, byte_last, idx held stable.
- DONE: burst_done=1 for exactly one cycle, -> IDLE. block_count holds final value until next start.
- byte_last = byte_valid && idx==63.
- Byte index is 6 bits and never wraps inside SEND; it is reset on every block capture.
- block_count saturates by construction (cannot exceed NUM_MATRICES).
- start outside IDLE is ignored; block_valid outside WAIT_BLK is ignored (no capture, no error).
- Zero-valued bytes and repeated equal bytes are transmitted as ordinary bytes, each with its own handshake.

## Timing
- Reset (async assert, sync release at next edge): state=IDLE, block_ready=0, byte_valid=0, byte_out=0, byte_last=0, busy=0, block_count=0, burst_done=0, holding register=0, idx=0.
- Reset mid-burst: immediate abort, all outputs to reset values; partial block discarded, no burst_done.
- start at edge N -> block_ready=1 from N+1.
- Block captured at edge M -> byte_valid=1 with byte 0 from M+1.
- With byte_ready held high: 64 consecutive bytes, one per cycle, edges M+1..M+64; last byte accepted at edge M+64.
- After last byte of a non-final block: WAIT_BLK at M+65, byte_valid=0 at least one cycle between blocks; next capture no earlier than edge M+65.
- After last byte of final block: burst_done=1 during cycle after acceptance edge, busy stays 1 in DONE, IDLE (busy=0) next cycle.
- Outputs are registered; no combinational path from byte_ready to byte_out/byte_valid.
- block_ready is combinational from state only (not from block_valid).

## Test plan
- Reset then start, one block where word k = 32'h03020100 + k*32'h04040404 -> byte_out sequence 0x00,0x01,...,0x3F on 64 consecutive cycles, byte_last only on 0x3F, block_count=1 after.
- NUM_MATRICES=2 burst, byte_ready always 1 -> 128 bytes, block_ready high only in WAIT_BLK, burst_done single pulse after byte 127, busy falls next cycle, block_count=2.
- Random byte_ready stalls (~50%) on all-zero block -> exactly 64 transfers of 0x00, byte_out/byte_last stable across every stall cycle.
- block_valid asserted while in SEND with a different matrix -> ignored; output continues from captured matrix; new matrix captured only in next WAIT_BLK.
- Assert rst at byte 30 of block 1 -> all outputs at reset values immediately (before next edge); no burst_done; subsequent start transmits a fresh burst from byte 0, block_count=0.
- start pulsed during SEND and DONE -> no effect on state, idx or block_count.

Source files
------------

// File: rtl/keystream_serialiser.sv
// rtl/keystream_serialiser.sv - byte-serial transmitter for ChaCha20 state matrices
//
// Accepts one NUM_WORDS x WORD_SIZE state matrix per handshake and emits it
// as DATA_SIZE-bit bytes, one per accepted cycle, in RFC 8439 order. The matrix
// is sent word 0 first, and each word is sent little-endian. After
// NUM_MATRICES blocks the burst completes with a one-cycle burst_done pulse.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst          in   asynchronous active-high reset
//   start        in   begin a burst (sampled only in IDLE)
//   block_valid  in   block_in holds a valid matrix
//   block_in     in   state matrix, unpacked [0:NUM_WORDS-1], word 0 first
//   block_ready  out  serialiser can capture a matrix (WAIT_BLK only)
//   byte_out     out  current output byte
//   byte_valid   out  byte_out is valid
//   byte_ready   in   downstream accepts the byte this cycle
//   byte_last    out  byte_out is the final byte of its block
//   busy         out  high in any state other than IDLE
//   block_count  out  blocks fully transmitted in the current burst
//   burst_done   out  one-cycle pulse after the final byte of the burst

module keystream_serialiser #(
    parameter int DATA_SIZE    = 8,
    parameter int WORD_SIZE    = 32,
    parameter int NUM_WORDS    = 16,
    parameter int NUM_MATRICES = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                block_valid,
    input  logic [WORD_SIZE-1:0]                block_in [0:NUM_WORDS-1],
    output logic                                block_ready,
    output logic [DATA_SIZE-1:0]                byte_out,
    output logic                                byte_valid,
    input  logic                                byte_ready,
    output logic                                byte_last,
    output logic                                busy,
    output logic [$clog2(NUM_MATRICES+1)-1:0]   block_count,
    output logic                                burst_done
);

    localparam int BLK_BITS  = NUM_WORDS * WORD_SIZE;
    localparam int NUM_BYTES = BLK_BITS / DATA_SIZE;
    localparam int IDX_W     = $clog2(NUM_BYTES);
    localparam int CNT_W     = $clog2(NUM_MATRICES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(NUM_MATRICES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [BLK_BITS-1:0]    r_hold;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_count;
    logic [DATA_SIZE-1:0]   r_byte_out;
    logic                   r_byte_valid;
    logic                   r_byte_last;

    logic [BLK_BITS-1:0]    w_blk_flat;
    logic [IDX_W-1:0]       w_idx_next;
    logic [CNT_W-1:0]       w_count_inc;
    logic                   w_start_burst;
    logic                   w_capture;
    logic                   w_xfer;
    logic                   w_blk_end;

    // Word k occupies bits [k*WORD_SIZE +: WORD_SIZE], so byte index i of the
    // serial stream sits at bits [i*DATA_SIZE +: DATA_SIZE] of the flat vector.
    always_comb begin
        w_blk_flat = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            w_blk_flat[k*WORD_SIZE +: WORD_SIZE] = block_in[k];
        end
    end

    assign w_idx_next  = r_idx + 1'b1;
    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_burst = 1'b0;
        w_capture     = 1'b0;
        w_xfer        = 1'b0;
        w_blk_end     = 1'b0;
        block_ready   = 1'b0;
        busy          = 1'b1;
        burst_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start_burst = 1'b1;
                    w_next        = S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: begin
                block_ready = 1'b1;
                if (block_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_SEND;
                end
            end
            S_SEND: begin
                if (r_byte_valid && byte_ready) begin
                    w_xfer = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_blk_end = 1'b1;
                        w_next    = (w_count_inc == FINAL_CNT) ? S_DONE : S_WAIT_BLK;
                    end
                end
            end
            S_DONE: begin
                burst_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Byte outputs are registered: the next byte is fetched from the holding
    // register on each transfer, so byte_ready never reaches byte_out
    // combinationally. The index stops at the last byte instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
        end else begin
            if (w_start_burst) begin
                r_count <= '0;
            end else if (w_blk_end) begin
                r_count <= w_count_inc;
            end

            if (w_capture) begin
                r_hold       <= w_blk_flat;
                r_idx        <= '0;
                r_byte_out   <= w_blk_flat[DATA_SIZE-1:0];
                r_byte_valid <= 1'b1;
                r_byte_last  <= (NUM_BYTES == 1);
            end else if (w_xfer) begin
                if (w_blk_end) begin
                    r_byte_valid <= 1'b0;
                    r_byte_last  <= 1'b0;
                end else begin
                    r_idx       <= w_idx_next;
                    r_byte_out  <= r_hold[int'(w_idx_next)*DATA_SIZE +: DATA_SIZE];
                    r_byte_last <= (w_idx_next == LAST_IDX);
                end
            end
        end
    end

    assign byte_out    = r_byte_out;
    assign byte_valid  = r_byte_valid;
    assign byte_last   = r_byte_last;
    assign block_count = r_count;

endmodule

// File: tb/tb_keystream_serialiser.sv
// tb/tb_keystream_serialiser.sv - scoreboard bench for keystream_serialiser
module tb_keystream_serialiser;

    localparam int NM = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        block_valid = 1'b0;
    logic        byte_ready = 1'b0;
    logic [31:0] drv_blk [0:15];
    logic        block_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_last;
    logic        busy;
    logic [1:0]  block_count;
    logic        burst_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_pulses = 0;
    logic [8:0]  sb_q [$];

    always #5 clk = ~clk;

    keystream_serialiser #(
        .DATA_SIZE    (8),
        .WORD_SIZE    (32),
        .NUM_WORDS    (16),
        .NUM_MATRICES (NM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .block_valid (block_valid),
        .block_in    (drv_blk),
        .block_ready (block_ready),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_last   (byte_last),
        .busy        (busy),
        .block_count (block_count),
        .burst_done  (burst_done)
    );

    always @(negedge clk) begin
        if (burst_done) done_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Hands drv_blk to the DUT, then drains the block.
    // intrude: keep block_valid high with a zero matrix during SEND.
    // start_at: pulse start while this byte index is pending.
    // abort_at: return (without draining) when this byte index is pending.
    task automatic send_block(input int stall_pct, input bit intrude,
                              input int start_at, input int abort_at);
        int         n;
        int         got;
        int         cyc;
        bit         stalled;
        logic [8:0] held;
        logic [8:0] exp;
        n = 0;
        sb_q.delete();
        block_valid = 1'b1;
        while (!block_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("blk_ready_wait", block_ready, 1);
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back({i == 63, drv_blk[i/4][8*(i%4) +: 8]});
        end
        @(negedge clk);
        if (intrude) begin
            for (int k = 0; k < 16; k++) drv_blk[k] = 32'h0;
        end else begin
            block_valid = 1'b0;
        end
        got     = 0;
        cyc     = 0;
        stalled = 0;
        held    = '0;
        byte_ready = ($urandom_range(0, 99) >= stall_pct);
        while (got < 64 && cyc < 2000) begin
            if (abort_at >= 0 && got == abort_at) break;
            start = (got == start_at);
            check_eq("valid_in_send", byte_valid, 1);
            check_eq("ready_in_send", block_ready, 0);
            if (stalled) begin
                check_eq("stall_byte", byte_out, held[7:0]);
                check_eq("stall_last", byte_last, held[8]);
            end
            if (byte_ready) begin
                exp = sb_q.pop_front();
                check_eq("byte", byte_out, exp[7:0]);
                check_eq("last", byte_last, exp[8]);
                got++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = {byte_last, byte_out};
            end
            @(negedge clk);
            cyc++;
            byte_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        start = 1'b0;
        if (abort_at < 0) check_eq("blk_bytes", got, 64);
    endtask

    task automatic rand_block();
        for (int k = 0; k < 16; k++) drv_blk[k] = $urandom();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) drv_blk[k] = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_block_ready", block_ready, 0);
        check_eq("rst_byte_valid", byte_valid, 0);
        check_eq("rst_byte_out", byte_out, 0);
        check_eq("rst_byte_last", byte_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_block_count", block_count, 0);
        check_eq("rst_burst_done", burst_done, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_block_ready", block_ready, 0);

        // Burst 1: ramp block with an intruding matrix, then stalled zero block.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_block_ready", block_ready, 1);
        check_eq("start_busy", busy, 1);
        check_eq("start_count", block_count, 0);
        check_eq("start_byte_valid", byte_valid, 0);
        for (int k = 0; k < 16; k++) drv_blk[k] = 32'h03020100 + k * 32'h04040404;
        send_block(0, 1'b1, -1, -1);
        check_eq("b0_count", block_count, 1);
        check_eq("b0_wait_ready", block_ready, 1);
        check_eq("b0_gap_valid", byte_valid, 0);
        send_block(50, 1'b0, 10, -1);
        check_eq("done_pulse", burst_done, 1);
        check_eq("done_busy", busy, 1);
        check_eq("done_valid", byte_valid, 0);
        check_eq("done_count", block_count, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("post_done_busy", busy, 0);
        check_eq("post_done_ready", block_ready, 0);
        check_eq("post_done_pulse", burst_done, 0);
        check_eq("post_done_count", block_count, 2);
        @(negedge clk);
        check_eq("idle_after_start_in_done", busy, 0);
        check_eq("pulses_b1", done_pulses, 1);

        // Burst 2: aborted by reset in the middle of the second block.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("b2_count_clear", block_count, 0);
        rand_block();
        send_block(0, 1'b0, -1, -1);
        check_eq("b2_count", block_count, 1);
        rand_block();
        send_block(30, 1'b0, -1, 30);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_block_ready", block_ready, 0);
        check_eq("abort_byte_valid", byte_valid, 0);
        check_eq("abort_byte_out", byte_out, 0);
        check_eq("abort_byte_last", byte_last, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_count", block_count, 0);
        check_eq("abort_burst_done", burst_done, 0);
        @(negedge clk);
        rst = 1'b0;
        byte_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pulses_after_abort", done_pulses, 1);
        check_eq("abort_idle_busy", busy, 0);

        // Burst 3: fresh burst after the abort.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("b3_count", block_count, 0);
        check_eq("b3_ready", block_ready, 1);
        rand_block();
        send_block(30, 1'b0, -1, -1);
        check_eq("b3_count1", block_count, 1);
        rand_block();
        send_block(0, 1'b0, -1, -1);
        check_eq("b3_done", burst_done, 1);
        check_eq("b3_count2", block_count, 2);
        @(negedge clk);
        check_eq("b3_busy_low", busy, 0);
        check_eq("pulses_b3", done_pulses, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
